count_event_monitor: RTL and testbench
======================================

Name: count_event_monitor

Overview:
- Downstream consumer of the 4-bit free-running state counter (dflop + ripple_adder incrementer).
- Samples the counter value every enabled clock and detects two events: wrap-around (all-ones -> zero) and match against a programmable compare value.
- Counts wraps into an epoch register.
- Latches events into a pending/acknowledge handshake for a slower control consumer.

Parameters:
- COUNT_W, 4, width of the monitored count bus.
- EPOCH_W, 8, width of the wrap (epoch) counter.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- count  input  COUNT_W  current counter value from the upstream counter.
- match_val  input  COUNT_W  compare value; sampled each enabled cycle.
- enable  input  1  sample qualifier; 0 = hold all state, pulses forced 0.
- ack  input  1  consumer acknowledge of pending event.
- wrap_pulse  output  1  one-cycle pulse on a detected wrap.
- match_pulse  output  1  one-cycle pulse on a detected match.
- epoch  output  EPOCH_W  number of wraps since reset, modulo 2^EPOCH_W.
- event_pending  output  1  an unacknowledged event exists.
- event_code  output  2  bit0 = match seen, bit1 = wrap seen, accumulated while pending.
- event_overrun  output  1  sticky: event arrived while pending and not acked.
- step_error  output  1  sticky sequence-check flag (see Optional Feature).

Behaviour:
- Reset (clock edge with reset=1): all outputs 0, prev_count = 0, sampler FSM -> INIT, handshake FSM -> IDLE. Reset overrides every other input, including mid-pending.
- Sampler FSM:
  - INIT: on the first enable=1 cycle, capture count into prev_count, raise no events, go to RUN.
  - RUN: each enable=1 cycle, evaluate events, then prev_count <= count.
  - enable=0 in either state: no state change, no pulses.
- Wrap event (RUN, enable=1): prev_count == all-ones and count == 0.
- Match event (RUN, enable=1): count == match_val and count != prev_count. A held count therefore produces one match, not repeated matches.
- Latency: wrap_pulse and match_pulse are registered and assert the cycle after the sampling edge, for exactly one cycle. Both may assert together, e.g. match_val = 0 at wrap.
- epoch increments by 1 on the same edge that registers wrap_pulse; it wraps from all-ones to 0 with no flag.
- Handshake FSM:
  - IDLE: on any event, go to PENDING, event_pending = 1, event_code = {wrap, match}.
  - PENDING, ack=0, new event: event_code |= new bits; event_overrun <= 1.
  - PENDING, ack=1, no new event: go to IDLE, event_code = 0, event_overrun = 0.
  - PENDING, ack=1, new event same cycle: stay in PENDING, event_code = new bits only, event_overrun = 0. The new event is not lost.
  - ack in IDLE is ignored.
- event_pending, event_code and event_overrun update on the same edge as the pulses.
- All arithmetic is unsigned; no other widths are truncated.

Optional Feature:
- Macro COUNT_EVENT_STEP_CHECK_EN.
- Defined: in RUN with enable=1, if count != (prev_count + 1) mod 2^COUNT_W and count != prev_count, set step_error (sticky, cleared only by reset). This catches skipped or corrupted counter states from the flop/adder chain.
- Not defined: step_error is tied to 0 and the comparator logic is absent.

Test Plan:
- Reset then enable=1, count 0,1,2...15,0 with match_val=5:
  - match_pulse is high exactly one cycle after the count=5 sample.
  - wrap_pulse is high one cycle after the 15->0 sample.
  - epoch = 1.
  - No event on the first sample after reset.
- match_val=0 across a wrap -> wrap_pulse and match_pulse are high in the same cycle; event_code = 2'b11.
- Event occurs, ack held 0, second event occurs -> event_overrun = 1 and event_code is the OR of both. Then ack=1 with no event -> pending, code and overrun all 0 the next cycle.
- Pending match, ack=1 on the same cycle a wrap is detected -> event_pending stays 1, event_code = 2'b10, event_overrun = 0.
- Count held at 7 with match_val=7 for 4 cycles, enable=1 -> exactly one match_pulse. Then enable=0 while count changes -> no pulses and prev_count unchanged.
- Macro defined, count sequence 3,4,6 -> step_error = 1 after the 6 sample and stays 1 until reset. Macro undefined, same sequence -> step_error = 0.
- Assert reset while PENDING with epoch=3 -> next cycle all outputs 0; the first post-reset sample raises no event.

Source files
------------

// File: rtl/count_event_monitor.sv
// rtl/count_event_monitor.sv - wrap/match event monitor for a free-running state counter
//
// Samples an upstream counter each enabled clock, pulses on wrap-around
// (all-ones -> zero) and on a new match against match_val, counts wraps into
// epoch, and latches events into a pending/ack handshake for a slow consumer.
//
// Optional feature macro: COUNT_EVENT_STEP_CHECK_EN (sequence-step checker).
//
// Ports:
//   clock         in   system clock, rising edge
//   reset         in   synchronous active-high reset
//   count         in   [COUNT_W] monitored counter value
//   match_val     in   [COUNT_W] compare value
//   enable        in   sample qualifier; 0 holds all state
//   ack           in   consumer acknowledge of pending event
//   wrap_pulse    out  one-cycle pulse on wrap
//   match_pulse   out  one-cycle pulse on match
//   epoch         out  [EPOCH_W] wraps since reset, modulo 2^EPOCH_W
//   event_pending out  unacknowledged event exists
//   event_code    out  [2] {wrap seen, match seen}
//   event_overrun out  sticky: event arrived while pending and not acked
//   step_error    out  sticky sequence-check flag
module count_event_monitor #(
  parameter int COUNT_W = 4,
  parameter int EPOCH_W = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [COUNT_W-1:0] count,
  input  logic [COUNT_W-1:0] match_val,
  input  logic               enable,
  input  logic               ack,
  output logic               wrap_pulse,
  output logic               match_pulse,
  output logic [EPOCH_W-1:0] epoch,
  output logic               event_pending,
  output logic [1:0]         event_code,
  output logic               event_overrun,
  output logic               step_error
);

  typedef enum logic {S_INIT, S_RUN} samp_t;
  typedef enum logic {H_IDLE, H_PENDING} hs_t;

  localparam logic [COUNT_W-1:0] ALL_ONES = '1;
  localparam logic [COUNT_W-1:0] ZERO     = '0;

  samp_t              samp_state, samp_next;
  hs_t                hs_state, hs_next;
  logic [COUNT_W-1:0] prev_count;
  logic [1:0]         code_next;
  logic               overrun_next;

  logic               sample_run;
  logic               wrap_det;
  logic               match_det;
  logic [1:0]         new_code;
  logic               any_event;
  logic               ack_eff;

  // Event detection: only in RUN with enable, so disabled cycles raise nothing.
  always_comb begin
    sample_run = enable && (samp_state == S_RUN);
    wrap_det   = sample_run && (prev_count == ALL_ONES) && (count == ZERO);
    // A held count must not re-trigger the match.
    match_det  = sample_run && (count == match_val) && (count != prev_count);
    new_code   = {wrap_det, match_det};
    any_event  = wrap_det || match_det;
    // Disabled cycles hold all state, including the handshake.
    ack_eff    = enable && ack;
  end

  // Sampler FSM: state register
  always_ff @(posedge clock) begin
    if (reset) begin
      samp_state <= S_INIT;
    end else begin
      samp_state <= samp_next;
    end
  end

  // Sampler FSM: next state
  always_comb begin
    samp_next = samp_state;
    if (enable && samp_state == S_INIT) begin
      samp_next = S_RUN;
    end
  end

  // Sampler datapath: prev_count, pulses, epoch
  always_ff @(posedge clock) begin
    if (reset) begin
      prev_count  <= ZERO;
      wrap_pulse  <= 1'b0;
      match_pulse <= 1'b0;
      epoch       <= '0;
    end else begin
      wrap_pulse  <= wrap_det;
      match_pulse <= match_det;
      if (enable) begin
        prev_count <= count;
      end
      if (wrap_det) begin
        epoch <= epoch + EPOCH_W'(1);
      end
    end
  end

  // Handshake FSM: state register
  always_ff @(posedge clock) begin
    if (reset) begin
      hs_state      <= H_IDLE;
      event_code    <= 2'b00;
      event_overrun <= 1'b0;
    end else begin
      hs_state      <= hs_next;
      event_code    <= code_next;
      event_overrun <= overrun_next;
    end
  end

  // Handshake FSM: next state
  always_comb begin
    hs_next      = hs_state;
    code_next    = event_code;
    overrun_next = event_overrun;
    case (hs_state)
      H_IDLE: begin
        if (any_event) begin
          hs_next   = H_PENDING;
          code_next = new_code;
        end
      end
      H_PENDING: begin
        if (ack_eff) begin
          // An event coinciding with ack starts a fresh pending window.
          overrun_next = 1'b0;
          code_next    = new_code;
          if (!any_event) begin
            hs_next = H_IDLE;
          end
        end else if (any_event) begin
          code_next    = event_code | new_code;
          overrun_next = 1'b1;
        end
      end
      default: hs_next = H_IDLE;
    endcase
  end

  // Handshake FSM: outputs
  always_comb begin
    event_pending = (hs_state == H_PENDING);
  end

`ifdef COUNT_EVENT_STEP_CHECK_EN
  logic [COUNT_W-1:0] prev_inc;
  logic               step_bad;

  always_comb begin
    prev_inc = prev_count + COUNT_W'(1);
    step_bad = sample_run && (count != prev_inc) && (count != prev_count);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      step_error <= 1'b0;
    end else if (step_bad) begin
      step_error <= 1'b1;
    end
  end
`else
  assign step_error = 1'b0;
`endif

endmodule

// File: tb/tb_count_event_monitor.sv
// tb/tb_count_event_monitor.sv - self-checking bench for count_event_monitor
module tb_count_event_monitor;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] count;
  logic [3:0] match_val;
  logic       enable;
  logic       ack;
  logic       wrap_pulse;
  logic       match_pulse;
  logic [7:0] epoch;
  logic       event_pending;
  logic [1:0] event_code;
  logic       event_overrun;
  logic       step_error;

  int checks = 0;
  int errors = 0;

  count_event_monitor #(.COUNT_W(4), .EPOCH_W(8)) dut (
    .clock         (clock),
    .reset         (reset),
    .count         (count),
    .match_val     (match_val),
    .enable        (enable),
    .ack           (ack),
    .wrap_pulse    (wrap_pulse),
    .match_pulse   (match_pulse),
    .epoch         (epoch),
    .event_pending (event_pending),
    .event_code    (event_code),
    .event_overrun (event_overrun),
    .step_error    (step_error)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic       wrap;
    logic       match;
    logic [7:0] epoch;
    logic       pend;
    logic [1:0] code;
    logic       ovr;
    logic       step;
  } exp_t;

  exp_t exp_q[$];

  // Behavioural reference model state
  logic       m_run;
  logic [3:0] m_prev;
  exp_t       m;

`ifdef COUNT_EVENT_STEP_CHECK_EN
  localparam bit STEP_EN = 1'b1;
`else
  localparam bit STEP_EN = 1'b0;
`endif

  task automatic model_step(input logic rst, input logic en, input logic ak,
                            input logic [3:0] cnt, input logic [3:0] mv);
    logic w, mt;
    logic [3:0] nxt;
    if (rst) begin
      m_run  = 1'b0;
      m_prev = 4'd0;
      m      = '0;
    end else if (!en) begin
      m.wrap  = 1'b0;
      m.match = 1'b0;
    end else if (!m_run) begin
      m_run   = 1'b1;
      m_prev  = cnt;
      m.wrap  = 1'b0;
      m.match = 1'b0;
    end else begin
      w   = (m_prev == 4'hF) && (cnt == 4'h0);
      mt  = (cnt == mv) && (cnt != m_prev);
      nxt = m_prev + 4'd1;
      if (STEP_EN && cnt != nxt && cnt != m_prev) m.step = 1'b1;
      m.wrap  = w;
      m.match = mt;
      if (w) m.epoch = m.epoch + 8'd1;
      if (!m.pend) begin
        if (w || mt) begin
          m.pend = 1'b1;
          m.code = {w, mt};
        end
      end else if (ak) begin
        m.ovr  = 1'b0;
        m.code = {w, mt};
        if (!(w || mt)) m.pend = 1'b0;
      end else if (w || mt) begin
        m.code = m.code | {w, mt};
        m.ovr  = 1'b1;
      end
      m_prev = cnt;
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Drive one cycle, push the model's expectation, then pop and compare after the edge.
  task automatic step(input logic rst, input logic en, input logic ak,
                      input logic [3:0] cnt, input logic [3:0] mv);
    exp_t e;
    reset     = rst;
    enable    = en;
    ack       = ak;
    count     = cnt;
    match_val = mv;
    model_step(rst, en, ak, cnt, mv);
    exp_q.push_back(m);
    @(posedge clock);
    #1;
    e = exp_q.pop_front();
    chk("wrap_pulse",    {7'd0, wrap_pulse},    {7'd0, e.wrap});
    chk("match_pulse",   {7'd0, match_pulse},   {7'd0, e.match});
    chk("epoch",         epoch,                 e.epoch);
    chk("event_pending", {7'd0, event_pending}, {7'd0, e.pend});
    chk("event_code",    {6'd0, event_code},    {6'd0, e.code});
    chk("event_overrun", {7'd0, event_overrun}, {7'd0, e.ovr});
    chk("step_error",    {7'd0, step_error},    {7'd0, e.step});
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; ack = 1'b0; count = 4'd0; match_val = 4'd0;
    m_run = 1'b0; m_prev = 4'd0; m = '0;

    // Step-check sequence 3,4,6 (then legal steps): sticky only when enabled.
    step(1, 0, 0, 4'd0, 4'd0);
    step(0, 1, 0, 4'd3, 4'd9);
    step(0, 1, 0, 4'd4, 4'd9);
    step(0, 1, 0, 4'd6, 4'd9);
    chk("step_after_6", {7'd0, step_error}, {7'd0, STEP_EN});
    step(0, 1, 0, 4'd7, 4'd9);
    step(0, 1, 0, 4'd8, 4'd9);
    chk("step_sticky", {7'd0, step_error}, {7'd0, STEP_EN});

    // Reset, then full count 0..15,0 with match_val=5.
    step(1, 0, 0, 4'd0, 4'd0);
    chk("reset_pending", {7'd0, event_pending}, 8'd0);
    chk("reset_step",    {7'd0, step_error},    8'd0);
    step(0, 1, 0, 4'd0, 4'd5);
    chk("first_no_event", {6'd0, wrap_pulse, match_pulse}, 8'd0);
    for (int i = 1; i < 16; i++) begin
      step(0, 1, 0, 4'(i), 4'd5);
      if (i == 5) chk("match_at_5", {7'd0, match_pulse}, 8'd1);
      if (i == 6) chk("match_one_cycle", {7'd0, match_pulse}, 8'd0);
    end
    step(0, 1, 0, 4'd0, 4'd5);
    chk("wrap_at_0", {7'd0, wrap_pulse}, 8'd1);
    chk("epoch_1", epoch, 8'd1);
    chk("ovr_match_then_wrap", {7'd0, event_overrun}, 8'd1);
    step(0, 1, 1, 4'd0, 4'd5);
    chk("ack_clears", {5'd0, event_pending, event_code}, 8'd0);

    // match_val=0 across a wrap: both pulses together.
    step(0, 1, 0, 4'd14, 4'd0);
    step(0, 1, 0, 4'd15, 4'd0);
    step(0, 1, 0, 4'd0, 4'd0);
    chk("both_pulses", {6'd0, wrap_pulse, match_pulse}, 8'd3);
    chk("code_11", {6'd0, event_code}, 8'd3);
    step(0, 1, 1, 4'd0, 4'd0);

    // Overrun: match then wrap with no ack, then ack with no event.
    for (int i = 1; i < 16; i++) step(0, 1, 0, 4'(i), 4'd3);
    step(0, 1, 0, 4'd0, 4'd3);
    chk("overrun_set", {7'd0, event_overrun}, 8'd1);
    chk("overrun_code", {6'd0, event_code}, 8'd3);
    step(0, 1, 1, 4'd0, 4'd3);
    chk("overrun_clear", {5'd0, event_pending, event_overrun, event_code[0]}, 8'd0);

    // Pending match, ack on the same cycle a wrap is detected.
    for (int i = 1; i < 16; i++) step(0, 1, 0, 4'(i), 4'd15);
    step(0, 1, 1, 4'd0, 4'd15);
    chk("ack_wrap_pend", {7'd0, event_pending}, 8'd1);
    chk("ack_wrap_code", {6'd0, event_code}, 8'd2);
    chk("ack_wrap_ovr",  {7'd0, event_overrun}, 8'd0);
    step(0, 1, 1, 4'd0, 4'd15);

    // Held count 7 with match_val=7: one match; then disabled count changes.
    for (int i = 1; i < 7; i++) step(0, 1, 1, 4'(i), 4'd7);
    step(0, 1, 0, 4'd7, 4'd7);
    chk("held_first_match", {7'd0, match_pulse}, 8'd1);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 4'd7, 4'd7);
      chk("held_no_rematch", {7'd0, match_pulse}, 8'd0);
    end
    step(0, 1, 1, 4'd7, 4'd7);
    step(0, 0, 0, 4'd9, 4'd9);
    step(0, 0, 0, 4'd12, 4'd12);
    chk("disabled_no_pulse", {6'd0, wrap_pulse, match_pulse}, 8'd0);
    step(0, 1, 0, 4'd8, 4'd0);
    chk("prev_held_no_step", {7'd0, step_error}, 8'd0);

    // Three wraps left pending, then reset mid-pending.
    step(1, 0, 0, 4'd0, 4'd0);
    step(0, 1, 0, 4'd15, 4'd0);
    for (int w = 0; w < 3; w++) begin
      step(0, 1, 0, 4'd0, 4'd9);
      step(0, 1, 0, 4'd15, 4'd9);
    end
    chk("epoch_3", epoch, 8'd3);
    chk("pending_before_reset", {7'd0, event_pending}, 8'd1);
    step(1, 1, 0, 4'd0, 4'd0);
    chk("reset_all_zero", {wrap_pulse, match_pulse, event_pending, event_code,
                           event_overrun, step_error, 1'b0}, 8'd0);
    chk("reset_epoch", epoch, 8'd0);
    step(0, 1, 0, 4'd0, 4'd0);
    chk("post_reset_no_event", {6'd0, wrap_pulse, match_pulse}, 8'd0);
    step(0, 1, 0, 4'd0, 4'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
